// File: rtl/ps2_pkg.sv
// ps2_pkg: shared deframer state encoding and PS/2 frame constants
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  localparam logic PS2_START_BIT = 1'b0;
  localparam logic PS2_STOP_BIT  = 1'b1;
  localparam int   PS2_DATA_BITS = 8;
endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: scan-code read port between the PS/2 receiver and the keyboard register block
interface ps2_rx_fifo_if #(parameter int DEPTH = 32);
  logic                     rd_en;
  logic                     ovf_clr;
  logic [7:0]               rd_data;
  logic                     empty;
  logic                     full;
  logic [$clog2(DEPTH):0]   count;
  logic                     frame_err;
  logic                     overflow;
  modport master (output rd_en, ovf_clr, input rd_data, empty, full, count, frame_err, overflow);
  modport slave  (input rd_en, ovf_clr, output rd_data, empty, full, count, frame_err, overflow);
endinterface

// File: rtl/ps2_sync_fifo.sv
// ps2_sync_fifo: show-ahead FIFO; head entry is visible on rdata_o whenever not empty
module ps2_sync_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                     system_clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o  = count_q == CW'(DEPTH);
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  // storage array, written at the tail on an accepted push
  always_ff @(posedge system_clk)
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  // pointers wrap naturally at DEPTH; occupancy moves only on a lone push or pop
  always_ff @(posedge system_clk or posedge reset)
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_q + AW'(do_pop);
      count_q  <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 deframer feeding a scan-code FIFO; PS2_RX_TIMEOUT_EN adds a partial-frame watchdog
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic           system_clk,
  input  logic           reset,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_rx_fifo_if.slave   bus
);
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q, fall_q, bit_q;
  ps2_state_e             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d, push_q, push_d, err_q, err_d, ovf_q, ovf_d;
  logic                   fifo_full;
  // synchronise both lines; idle bus level is high
  always_ff @(posedge system_clk or posedge reset)
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      bit_q       <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
      fall_q      <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
      bit_q       <= data_sync_q[SYNC_STAGES-1];
    end
`ifdef PS2_RX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          wd_expired;
  assign wd_expired = state_q != IDLE && !fall_q && wd_q == WW'(TIMEOUT_CYCLES - 1);
  assign wd_d = (state_q == IDLE || fall_q || wd_expired) ? '0 : wd_q + WW'(1);
  // watchdog counts idle cycles inside a frame
  always_ff @(posedge system_clk or posedge reset)
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
`else
  logic wd_expired;
  assign wd_expired = 1'b0;
`endif
  // deframer next state: one bit consumed per detected falling edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    push_d  = 1'b0;
    err_d   = 1'b0;
    if (wd_expired) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall_q)
      unique case (state_q)
        IDLE: if (bit_q == PS2_START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = {bit_q, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          state_d = cnt_q == 3'(PS2_DATA_BITS - 1) ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = bit_q;
          state_d = STOP;
        end
        STOP: begin
          push_d  = bit_q == PS2_STOP_BIT && (^shift_q ^ par_q);
          err_d   = !push_d;
          state_d = IDLE;
        end
      endcase
  end
  // deframer registers and the registered push / error strobes
  always_ff @(posedge system_clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      push_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      push_q  <= push_d;
      err_q   <= err_d;
    end
  // a byte is lost only when full and the reader does not free a slot that cycle; a new loss beats clear
  assign ovf_d = (push_q & fifo_full & ~bus.rd_en) | (ovf_q & ~bus.ovf_clr);
  // sticky overflow flag
  always_ff @(posedge system_clk or posedge reset)
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  assign bus.frame_err = err_q;
  assign bus.overflow  = ovf_q;
  assign bus.full      = fifo_full;
  ps2_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .system_clk (system_clk),
    .reset      (reset),
    .push_i     (push_q),
    .pop_i      (bus.rd_en),
    .wdata_i    (shift_q),
    .rdata_o    (bus.rd_data),
    .full_o     (fifo_full),
    .empty_o    (bus.empty),
    .count_o    (bus.count)
  );
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed frames against ps2_rx_fifo with DEPTH=4; timeout case when PS2_RX_TIMEOUT_EN is defined
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 50000;
`endif
  logic system_clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int tests = 0;
  int fails = 0;
  int err_cycles = 0;
  int long_err = 0;
  logic err_prev = 1'b0;
  int lat;
  ps2_rx_fifo_if #(.DEPTH(DEPTH)) bus();
  ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)) dut (
    .system_clk (system_clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .bus        (bus)
  );
  always #5 system_clk = ~system_clk;
  always @(negedge system_clk) begin
    if (bus.frame_err) err_cycles++;
    if (bus.frame_err && err_prev) long_err++;
    err_prev = bus.frame_err;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic ps2_bit(input logic b);
    @(negedge system_clk) ps2_data = b;
    repeat (5) @(negedge system_clk);
    ps2_clk = 1'b0;
    repeat (10) @(negedge system_clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge system_clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit pop_at_push, output int l);
    logic [10:0] f;
    logic [31:0] c0;
    f = {s, p, d, 1'b0};
    for (int k = 0; k < 10; k++) ps2_bit(f[k]);
    @(negedge system_clk) ps2_data = f[10];
    repeat (5) @(negedge system_clk);
    c0 = 32'(bus.count);
    l = 99;
    ps2_clk = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge system_clk);
      if (pop_at_push && i == 4) bus.rd_en = 1'b1;
      if (pop_at_push && i == 5) bus.rd_en = 1'b0;
      if (l == 99 && 32'(bus.count) != c0) l = i;
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge system_clk);
  endtask
  task automatic good(input logic [7:0] d);
    int l;
    send_frame(d, ~^d, 1'b1, 1'b0, l);
  endtask
  task automatic pop();
    @(negedge system_clk) bus.rd_en = 1'b1;
    @(negedge system_clk) bus.rd_en = 1'b0;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, " empty"}, 32'(bus.empty), 1);
    check({tag, " full"}, 32'(bus.full), 0);
    check({tag, " count"}, 32'(bus.count), 0);
    check({tag, " overflow"}, 32'(bus.overflow), 0);
    check({tag, " frame_err"}, 32'(bus.frame_err), 0);
    check({tag, " rd_data"}, 32'(bus.rd_data), 0);
  endtask
  initial begin
    int e0;
    bus.rd_en = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (4) @(negedge system_clk);
    check_reset_state("reset");
    reset = 1'b0;
    repeat (4) @(negedge system_clk);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, lat);
    check("latency", 32'(lat), SYNC + 3);
    check("1C data", 32'(bus.rd_data), 32'h1C);
    check("1C count", 32'(bus.count), 1);
    pop();
    check("1C popped empty", 32'(bus.empty), 1);
    good(8'hF0);
    good(8'h1C);
    check("order head F0", 32'(bus.rd_data), 32'hF0);
    pop();
    check("order next 1C", 32'(bus.rd_data), 32'h1C);
    pop();
    check("order empty", 32'(bus.empty), 1);
    check("no frame_err", 32'(err_cycles), 0);
    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, lat);
    check("parity err pulse", 32'(err_cycles), 1);
    check("parity err empty", 32'(bus.empty), 1);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, lat);
    check("stop err pulse", 32'(err_cycles), 2);
    check("stop err empty", 32'(bus.empty), 1);
    for (int k = 1; k <= 5; k++) good(8'(k));
    check("ovf full", 32'(bus.full), 1);
    check("ovf count", 32'(bus.count), 4);
    check("ovf flag", 32'(bus.overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf pop %0d", k), 32'(bus.rd_data), 32'(k));
      pop();
    end
    check("ovf drained", 32'(bus.empty), 1);
    check("ovf sticky", 32'(bus.overflow), 1);
    @(negedge system_clk) bus.ovf_clr = 1'b1;
    @(negedge system_clk) bus.ovf_clr = 1'b0;
    check("ovf cleared", 32'(bus.overflow), 0);
    for (int k = 1; k <= 4; k++) good(8'(k));
    send_frame(8'h05, 1'b1, 1'b1, 1'b1, lat);
    check("pushpop count", 32'(bus.count), 4);
    check("pushpop head", 32'(bus.rd_data), 32'h02);
    check("pushpop no ovf", 32'(bus.overflow), 0);
    pop();
    check("pushpop 03", 32'(bus.rd_data), 32'h03);
    pop();
    check("pushpop 04", 32'(bus.rd_data), 32'h04);
    pop();
    check("pushpop tail 05", 32'(bus.rd_data), 32'h05);
    pop();
    check("pushpop empty", 32'(bus.empty), 1);
    good(8'h11);
    check("pre-reset count", 32'(bus.count), 1);
    for (int k = 0; k < 4; k++) ps2_bit(k == 0 ? 1'b0 : 1'(k[0]));
    @(negedge system_clk) reset = 1'b1;
    repeat (3) @(negedge system_clk);
    check_reset_state("midreset");
    reset = 1'b0;
    repeat (4) @(negedge system_clk);
    good(8'h29);
    check("after reset 29", 32'(bus.rd_data), 32'h29);
    check("after reset count", 32'(bus.count), 1);
    pop();
`ifdef PS2_RX_TIMEOUT_EN
    e0 = err_cycles;
    for (int k = 0; k < 4; k++) ps2_bit(k == 0 ? 1'b0 : 1'(k[0]));
    repeat (150) @(negedge system_clk);
    check("timeout pulse", 32'(err_cycles - e0), 1);
    check("timeout empty", 32'(bus.empty), 1);
    good(8'h29);
    check("after timeout 29", 32'(bus.rd_data), 32'h29);
    check("after timeout count", 32'(bus.count), 1);
    pop();
`else
    e0 = 0;
`endif
    check("frame_err width", 32'(long_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
